// File: rtl/keypad_divider_seq_pkg.sv
// Shared types and constants for the keypad-fed divider.
package divider_pkg;

  // state  | meaning
  // CAP_A  | shifting hex keys into the dividend
  // CAP_B  | shifting hex keys into the divisor
  // DIVIDE | restoring divider iterating, keys dropped
  // DONE   | result held until the next key or cancel
  typedef enum logic [1:0] {CAP_A, CAP_B, DIVIDE, DONE} kdiv_state_t;

  localparam int KEY_W = 4;

endpackage

// File: rtl/keypad_divider_seq_div.sv
// Iterative restoring divider: one quotient bit per clock, W clocks after start.
module div_restoring
  import divider_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done
);

  localparam int CNTW = $clog2(W + 1);

  logic [W-1:0]    rem_q;
  logic [W-1:0]    q_q;
  logic [W-1:0]    dvs_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q;
  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic [W-1:0]    rem_nxt;
  logic [W-1:0]    q_nxt;

  // A restore only happens when shifted < divisor, so its top bit is 0 and
  // the kept remainder always fits in W bits.
  always_comb begin
    shifted = {rem_q, q_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    q_nxt   = {q_q[W-2:0], ~diff[W]};
  end

  // done flags the edge that completes the last iteration; the results are
  // presented combinationally so the parent can register them on that edge.
  assign done      = busy_q && (cnt_q == CNTW'(1));
  assign quotient  = q_nxt;
  assign remainder = rem_nxt;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      q_q    <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CNTW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      q_q   <= q_nxt;
      cnt_q <= cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_divider_seq.sv
// Keypad operand capture, divide sequencing and result/status registers.
module keypad_divider_seq
  import divider_pkg::*;
#(
  parameter int W = 8,
  localparam int NIB = W / 4,
  localparam int CW = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             cancel,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [CW-1:0]    nib_cnt
);

  kdiv_state_t  state, state_nxt;
  logic [W-1:0] a_nxt, b_nxt, q_nxt, r_nxt, a_shift, b_shift;
  logic [W-1:0] div_q, div_r;
  logic [CW-1:0] nib_nxt;
  logic         done_nxt, dbz_nxt, div_start, div_done, last_nib;

  // Cancel also aborts an in-flight division.
  div_restoring #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst | cancel),
    .start    (div_start),
    .dividend (a_out),
    .divisor  (b_shift),
    .quotient (div_q),
    .remainder(div_r),
    .busy     (busy),
    .done     (div_done)
  );

  always_comb begin
    a_shift   = (a_out << KEY_W) | W'(key_code);
    b_shift   = (b_out << KEY_W) | W'(key_code);
    last_nib  = (nib_cnt == CW'(NIB - 1));
    state_nxt = state;
    a_nxt     = a_out;
    b_nxt     = b_out;
    q_nxt     = quotient;
    r_nxt     = remainder;
    nib_nxt   = nib_cnt;
    done_nxt  = done;
    dbz_nxt   = div_by_zero;
    div_start = 1'b0;
    case (state)
      CAP_A: if (key_valid) begin
        a_nxt   = a_shift;
        nib_nxt = last_nib ? '0 : nib_cnt + CW'(1);
        if (last_nib) state_nxt = CAP_B;
      end
      CAP_B: if (key_valid) begin
        b_nxt   = b_shift;
        nib_nxt = last_nib ? '0 : nib_cnt + CW'(1);
        if (last_nib) begin
          if (b_shift == '0) begin
            q_nxt     = '0;
            r_nxt     = a_out;
            done_nxt  = 1'b1;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            div_start = 1'b1;
            state_nxt = DIVIDE;
          end
        end
      end
      DIVIDE: if (div_done) begin
        q_nxt     = div_q;
        r_nxt     = div_r;
        done_nxt  = 1'b1;
        dbz_nxt   = 1'b0;
        state_nxt = DONE;
      end
      DONE: if (key_valid) begin
        done_nxt  = 1'b0;
        dbz_nxt   = 1'b0;
        a_nxt     = W'(key_code);
        b_nxt     = '0;
        nib_nxt   = (NIB == 1) ? CW'(0) : CW'(1);
        state_nxt = (NIB == 1) ? CAP_B : CAP_A;
      end
      default: state_nxt = CAP_A;
    endcase
    if (cancel) begin
      state_nxt = CAP_A;
      a_nxt     = '0;
      b_nxt     = '0;
      q_nxt     = '0;
      r_nxt     = '0;
      nib_nxt   = '0;
      done_nxt  = 1'b0;
      dbz_nxt   = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CAP_A;
      a_out       <= '0;
      b_out       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      nib_cnt     <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_out       <= a_nxt;
      b_out       <= b_nxt;
      quotient    <= q_nxt;
      remainder   <= r_nxt;
      nib_cnt     <= nib_nxt;
      done        <= done_nxt;
      div_by_zero <= dbz_nxt;
    end
  end

endmodule
